// File: rtl/priority_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : priority_arbiter_pkg
// Purpose  : Shared types and helpers for the priority_arbiter_8 block:
//            arbiter state enum, grant-index width helper, default hold limit.
// Revision : 1.0 - initial release
// ============================================================================
package priority_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int DEFAULT_MAX_HOLD = 16;

    // Width of an encoded requester index; never below one bit.
    function automatic int calc_id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/priority_arbiter_8_pick.sv
`default_nettype none
// ============================================================================
// Module   : arb_pick
// Purpose  : Combinational rotated highest-first search. Starting at index
//            'start' and walking downwards with wrap-around, returns the first
//            set bit of 'vec'.
// Ports    : vec   [N-1:0]    candidate vector
//            start [ID_W-1:0] first index examined (highest rank)
//            idx   [ID_W-1:0] winning index (0 when none found)
//            found            high when vec has any bit set
// Revision : 1.0 - initial release
// ============================================================================
module arb_pick
    import priority_arbiter_pkg::*;
#(
    parameter int N    = 8,
    parameter int ID_W = calc_id_w(N)
) (
    input  logic [N-1:0]    vec,
    input  logic [ID_W-1:0] start,
    output logic [ID_W-1:0] idx,
    output logic            found
);

    logic [ID_W-1:0] w_pos;

    // Walk from the lowest rank up to the highest so the last hit, which is
    // the one closest to 'start', wins. N is a power of two, so the
    // subtraction wraps modulo N for free.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        w_pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = start - ID_W'(k);
            if (vec[w_pos]) begin
                idx   = w_pos;
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/priority_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module   : priority_arbiter_8
// Purpose  : Sequential arbiter for N requesters. Highest index wins; the
//            grant is registered and held until the owner drops its request
//            or MAX_HOLD consecutive cycles elapse (MAX_HOLD=0 disables the
//            limit). A timed-out owner is masked for the next arbitration.
// Option   : ROUND_ROBIN_EN - when defined, the search starts just below the
//            previous owner so that owner ranks lowest.
// Ports    : clk, rst (sync, active high)
//            req         [N-1:0]    request vector
//            grant       [N-1:0]    one-hot registered grant
//            grant_id    [ID_W-1:0] encoded owner (valid with grant_valid)
//            grant_valid            any grant bit set
//            timeout                one-cycle pulse on hold-limit revocation
// Revision : 1.0 - initial release
// ============================================================================
module priority_arbiter_8
    import priority_arbiter_pkg::*;
#(
    parameter int N        = 8,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    localparam int ID_W    = calc_id_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            grant_valid,
    output logic            timeout
);

    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] c_hold_max  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);
    localparam bit               c_to_en     = (MAX_HOLD > 0);

    arb_state_t       r_state,       w_state_nxt;
    logic [N-1:0]     r_grant,       w_grant_nxt;
    logic [ID_W-1:0]  r_grant_id,    w_grant_id_nxt;
    logic             r_timeout,     w_timeout_nxt;
    logic [CNT_W-1:0] r_hold_cnt,    w_hold_cnt_nxt;
    logic [ID_W-1:0]  r_last_id,     w_last_id_nxt;
    logic [N-1:0]     r_mask,        w_mask_nxt;
    logic             r_grant_valid;

    logic [N-1:0]     w_avail;
    logic [N-1:0]     w_cand;
    logic [ID_W-1:0]  w_start;
    logic [ID_W-1:0]  w_pick_id;
    logic             w_pick_found;
    logic             w_own_req;
    logic             w_hold_expired;

    // A masked (timed-out) requester is only reconsidered when nobody else
    // is asking, so a lone requester is never starved by its own mask.
    assign w_avail = req & ~r_mask;
    assign w_cand  = (w_avail != '0) ? w_avail : req;

`ifdef ROUND_ROBIN_EN
    assign w_start = r_last_id - ID_W'(1);
`else
    logic w_unused_last_id;
    assign w_start          = ID_W'(N - 1);
    assign w_unused_last_id = ^r_last_id;
`endif

    arb_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .vec   (w_cand),
        .start (w_start),
        .idx   (w_pick_id),
        .found (w_pick_found)
    );

    assign w_own_req      = req[r_grant_id];
    assign w_hold_expired = c_to_en && (r_hold_cnt == c_hold_last);

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_timeout_nxt  = 1'b0;
        w_hold_cnt_nxt = r_hold_cnt;
        w_last_id_nxt  = r_last_id;
        w_mask_nxt     = r_mask;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_grant_nxt    = N'(1) << w_pick_id;
                    w_grant_id_nxt = w_pick_id;
                    w_last_id_nxt  = w_pick_id;
                    w_hold_cnt_nxt = '0;
                    w_mask_nxt     = '0;
                    w_state_nxt    = BUSY;
                end
            end
            BUSY: begin
                if (r_hold_cnt != c_hold_max) begin
                    w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
                end
                // Release wins over a coincident hold-limit expiry.
                if (!w_own_req) begin
                    w_grant_nxt = '0;
                    w_state_nxt = IDLE;
                end else if (w_hold_expired) begin
                    w_grant_nxt   = '0;
                    w_timeout_nxt = 1'b1;
                    w_mask_nxt    = N'(1) << r_grant_id;
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_hold_cnt    <= '0;
            r_last_id     <= '0;
            r_mask        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_grant_valid <= (w_grant_nxt != '0);
            r_timeout     <= w_timeout_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
            r_last_id     <= w_last_id_nxt;
            r_mask        <= w_mask_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire
